piano_keyboard_renderer: RTL and testbench

Parametrised, pixel-streaming piano keyboard renderer for the 480x272 TFT panel. It replaces the fixed bank of per-key display instances with one block that generates panel timing, walks the key pattern incrementally, and colours every key from a frame-latched key-state vector. Pressed keys are highlighted. It sits between the 9 MHz pixel-enable divider and the panel RGB/DE/sync pins.

---
 rtl/piano_pkg.sv | 36 +++
 rtl/piano_keyboard_renderer_if.sv | 13 +
 rtl/piano_timing_gen.sv | 52 +++++
 rtl/piano_keyboard_renderer.sv | 189 ++++++++++++++++++
 tb/tb_piano_keyboard_renderer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano keyboard renderer: panel timing, fixed colours,
// key-pattern tables and the pixel classification type.
package piano_pkg;

  localparam int PNL_H_ACTIVE = 480;
  localparam int PNL_H_FP     = 2;
  localparam int PNL_H_SYNC   = 41;
  localparam int PNL_H_BP     = 2;
  localparam int PNL_H_TOTAL  = PNL_H_ACTIVE + PNL_H_FP + PNL_H_SYNC + PNL_H_BP;

  localparam int PNL_V_ACTIVE = 272;
  localparam int PNL_V_FP     = 2;
  localparam int PNL_V_SYNC   = 10;
  localparam int PNL_V_BP     = 2;
  localparam int PNL_V_TOTAL  = PNL_V_ACTIVE + PNL_V_FP + PNL_V_SYNC + PNL_V_BP;

  localparam int HCW = 10;
  localparam int VCW = 9;

  localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COL_BLACK = 24'h000000;

  // semitone of each white key within the octave, indexed by octave position p
  localparam logic [6:0][3:0] WHITE_SEMI = {4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};
  // bit p set: a black key sits to the right of white key p
  localparam logic [6:0] BLACK_MASK = 7'b0111011;

  typedef enum logic [2:0] {
    CLS_OFF,
    CLS_BG,
    CLS_BLACK,
    CLS_WHITE,
    CLS_EDGE
  } pix_cls_e;

endpackage

// File: rtl/piano_keyboard_renderer_if.sv
// Panel-side pixel bus of the piano keyboard renderer (RGB, DE, syncs, frame marker).
interface piano_keyboard_renderer_if;
  logic [7:0] data_RED;
  logic [7:0] data_GREEN;
  logic [7:0] data_BLUE;
  logic       DE;
  logic       hsync_n;
  logic       vsync_n;
  logic       frame_start;

  modport master (output data_RED, data_GREEN, data_BLUE, DE, hsync_n, vsync_n, frame_start);
  modport slave  (input  data_RED, data_GREEN, data_BLUE, DE, hsync_n, vsync_n, frame_start);
endinterface

// File: rtl/piano_timing_gen.sv
// Panel timing generator: h/v pixel counters advanced on pix_ce, raw data enable
// and active-low syncs decoded straight from the counters.
module piano_timing_gen
  import piano_pkg::*;
#(
  parameter int H_ACTIVE = PNL_H_ACTIVE,
  parameter int H_FP     = PNL_H_FP,
  parameter int H_SYNC   = PNL_H_SYNC,
  parameter int H_BP     = PNL_H_BP,
  parameter int V_ACTIVE = PNL_V_ACTIVE,
  parameter int V_FP     = PNL_V_FP,
  parameter int V_SYNC   = PNL_V_SYNC,
  parameter int V_BP     = PNL_V_BP
) (
  input  logic           Clk,
  input  logic           rst,
  input  logic           pix_ce,
  output logic [HCW-1:0] hcount,
  output logic [VCW-1:0] vcount,
  output logic           de_raw,
  output logic           hsync_raw_n,
  output logic           vsync_raw_n
);

  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SS   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SE   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_LAST = HCW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SS   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SE   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign de_raw      = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_raw_n = !((hcount >= H_SS) && (hcount < H_SE));
  assign vsync_raw_n = !((vcount >= V_SS) && (vcount < V_SE));

endmodule

// File: rtl/piano_keyboard_renderer.sv
// Pixel-streaming piano keyboard renderer: incremental key walker, frame-latched
// key state and a 2-stage classify/colour pipeline. KEY_OUTLINE_EN adds key separators.
module piano_keyboard_renderer
  import piano_pkg::*;
#(
  parameter int          OCTAVES  = 2,
  parameter int          WHITE_W  = 34,
  parameter int          BLACK_W  = 20,
  parameter int          KEY_H    = 200,
  parameter int          BLACK_H  = 120,
  parameter int          KB_TOP   = 36,
  parameter logic [23:0] HILITE_W = 24'h40C0FF,
  parameter logic [23:0] HILITE_B = 24'hC04000,
  parameter logic [23:0] BG       = 24'h202020,
  parameter int          H_ACTIVE = PNL_H_ACTIVE,
  parameter int          H_FP     = PNL_H_FP,
  parameter int          H_SYNC   = PNL_H_SYNC,
  parameter int          H_BP     = PNL_H_BP,
  parameter int          V_ACTIVE = PNL_V_ACTIVE,
  parameter int          V_FP     = PNL_V_FP,
  parameter int          V_SYNC   = PNL_V_SYNC,
  parameter int          V_BP     = PNL_V_BP
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    pix_ce,
  input  logic [12*OCTAVES-1:0]   key_down,
  piano_keyboard_renderer_if.master panel
);

  localparam int NKEYS = 12 * OCTAVES;
  localparam logic [HCW-1:0] H_ACT   = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_LAST  = HCW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HCW-1:0] KB_W    = HCW'(7 * OCTAVES * WHITE_W);
  localparam logic [VCW-1:0] KB_V0   = VCW'(KB_TOP);
  localparam logic [VCW-1:0] KB_V1   = VCW'(KB_TOP + KEY_H);
  localparam logic [VCW-1:0] BK_V1   = VCW'(KB_TOP + BLACK_H);
  localparam logic [7:0]     X_LAST  = 8'(WHITE_W - 1);
  localparam logic [7:0]     X_HALF  = 8'(BLACK_W / 2);
  localparam logic [7:0]     X_RIGHT = 8'(WHITE_W - BLACK_W / 2);
  localparam logic [7:0]     N_WHITE = 8'(7 * OCTAVES);

  logic [HCW-1:0] hcount;
  logic [VCW-1:0] vcount;
  logic           de_raw, hsync_raw_n, vsync_raw_n;

  piano_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .Clk(Clk), .rst(rst), .pix_ce(pix_ce),
    .hcount(hcount), .vcount(vcount),
    .de_raw(de_raw), .hsync_raw_n(hsync_raw_n), .vsync_raw_n(vsync_raw_n)
  );

  logic [NKEYS-1:0] key_q;
  logic             frame_pix;

  assign frame_pix = (hcount == '0) && (vcount == '0);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      key_q             <= '0;
      panel.frame_start <= 1'b0;
    end else begin
      panel.frame_start <= pix_ce && frame_pix;
      if (pix_ce && frame_pix) key_q <= key_down;
    end
  end

  // walker values describe the pixel at the current hcount; cleared ahead of hcount=0
  logic [7:0] w, x, b;
  logic [2:0] p;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      w <= '0;
      x <= '0;
      p <= '0;
      b <= '0;
    end else if (pix_ce) begin
      if (hcount == H_LAST) begin
        w <= '0;
        x <= '0;
        p <= '0;
        b <= '0;
      end else if (hcount < H_ACT) begin
        if (x == X_LAST) begin
          x <= '0;
          w <= w + 8'd1;
          if (p == 3'd6) begin
            p <= '0;
            b <= b + 8'd12;
          end else begin
            p <= p + 3'd1;
          end
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

  logic [2:0] p_prev;
  logic       blk_right, blk_left, in_kb, blk_line;
  pix_cls_e   cls;
  logic [7:0] idx;

  always_comb begin
    p_prev    = (p == 3'd0) ? 3'd6 : p - 3'd1;
    blk_right = BLACK_MASK[p] && ((w + 8'd1) < N_WHITE) && (x >= X_RIGHT);
    blk_left  = BLACK_MASK[p_prev] && (x < X_HALF);
    in_kb     = (vcount >= KB_V0) && (vcount < KB_V1) && (hcount < KB_W);
    blk_line  = vcount < BK_V1;
    idx       = b + {4'b0, WHITE_SEMI[p]};
    cls       = CLS_WHITE;
    if (!de_raw) begin
      cls = CLS_OFF;
    end else if (!in_kb) begin
      cls = CLS_BG;
    end else if (blk_line && blk_right) begin
      cls = CLS_BLACK;
      idx = b + {4'b0, WHITE_SEMI[p]} + 8'd1;
    end else if (blk_line && blk_left) begin
      cls = CLS_BLACK;
      idx = b + {4'b0, WHITE_SEMI[p_prev]} + 8'd1;
    end
`ifdef KEY_OUTLINE_EN
    else if (x == X_LAST) begin
      cls = CLS_EDGE;
    end
`endif
  end

  pix_cls_e   s1_cls;
  logic [7:0] s1_idx;
  logic       s1_de, s1_hs, s1_vs;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      s1_cls <= CLS_OFF;
      s1_idx <= '0;
      s1_de  <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
    end else if (pix_ce) begin
      s1_cls <= cls;
      s1_idx <= idx;
      s1_de  <= de_raw;
      s1_hs  <= hsync_raw_n;
      s1_vs  <= vsync_raw_n;
    end
  end

  logic [NKEYS-1:0] key_sel;
  logic             hit;
  logic [23:0]      rgb;

  always_comb begin
    key_sel = NKEYS'(1) << s1_idx;
    hit     = |(key_q & key_sel);
    case (s1_cls)
      CLS_BG:    rgb = BG;
      CLS_BLACK: rgb = hit ? HILITE_B : COL_BLACK;
      CLS_WHITE: rgb = hit ? HILITE_W : COL_WHITE;
      CLS_EDGE:  rgb = COL_BLACK;
      default:   rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      panel.data_RED   <= '0;
      panel.data_GREEN <= '0;
      panel.data_BLUE  <= '0;
      panel.DE         <= 1'b0;
      panel.hsync_n    <= 1'b1;
      panel.vsync_n    <= 1'b1;
    end else if (pix_ce) begin
      panel.data_RED   <= rgb[23:16];
      panel.data_GREEN <= rgb[15:8];
      panel.data_BLUE  <= rgb[7:0];
      panel.DE         <= s1_de;
      panel.hsync_n    <= s1_hs;
      panel.vsync_n    <= s1_vs;
    end
  end

endmodule

// File: tb/tb_piano_keyboard_renderer.sv
// Scoreboard bench for piano_keyboard_renderer on a reduced panel and one-octave keyboard;
// expected pixels are queued by the stimulus and checked by an independent monitor.
module tb_piano_keyboard_renderer;

  localparam int HA = 100, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 40,  VF = 2, VS = 3, VB = 2, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam logic [23:0] C_HW = 24'h40C0FF;
  localparam logic [23:0] C_HB = 24'hC04000;
  localparam logic [23:0] C_BG = 24'h202020;
  localparam logic [23:0] C_WH = 24'hFFFFFF;
  localparam logic [23:0] C_BK = 24'h000000;
`ifdef KEY_OUTLINE_EN
  localparam logic [23:0] EDGE_PRESSED = C_BK;
  localparam logic [23:0] EDGE_UNPR    = C_BK;
`else
  localparam logic [23:0] EDGE_PRESSED = C_HW;
  localparam logic [23:0] EDGE_UNPR    = C_WH;
`endif

  logic        Clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b0;
  logic [11:0] key_down = '0;

  piano_keyboard_renderer_if panel();

  piano_keyboard_renderer #(
    .OCTAVES(1), .WHITE_W(12), .BLACK_W(6), .KEY_H(24), .BLACK_H(14), .KB_TOP(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .Clk(Clk), .rst(rst), .pix_ce(pix_ce), .key_down(key_down), .panel(panel)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          epoch;
    int          pix;
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } probe_t;

  probe_t sb[$];
  int total = 0;
  int bad = 0;
  int epoch = 0;
  int n = 0;
  int m = 0;

  task automatic push(input int f, input int h, input int v, input logic [23:0] rgb,
                      input logic de, input logic hs, input logic vs);
    probe_t e;
    e.epoch = epoch; e.pix = f * FRAME + v * HT + h; e.h = h; e.v = v;
    e.rgb = rgb; e.de = de; e.hs = hs; e.vs = vs;
    sb.push_back(e);
  endtask

  task automatic px(input int f, input int h, input int v, input logic [23:0] rgb);
    push(f, h, v, rgb, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic check_out(input int op);
    probe_t e;
    logic [23:0] got;
    while (sb.size() > 0 && (sb[0].epoch < epoch || (sb[0].epoch == epoch && sb[0].pix < op))) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missed pixel(%0d,%0d) epoch %0d: never presented", e.h, e.v, e.epoch);
    end
    if (sb.size() > 0 && sb[0].epoch == epoch && sb[0].pix == op) begin
      e = sb.pop_front();
      got = {panel.data_RED, panel.data_GREEN, panel.data_BLUE};
      total++;
      if (got !== e.rgb || panel.DE !== e.de || panel.hsync_n !== e.hs || panel.vsync_n !== e.vs) begin
        bad++;
        $display("FAIL pixel(%0d,%0d) epoch %0d: got rgb=%h de=%b hs=%b vs=%b, want rgb=%h de=%b hs=%b vs=%b",
                 e.h, e.v, e.epoch, got, panel.DE, panel.hsync_n, panel.vsync_n,
                 e.rgb, e.de, e.hs, e.vs);
      end
    end
  endtask

  // monitor: output after pulse n shows pixel n-2 of the stream since reset
  always @(posedge Clk) begin
    if (!rst) begin
      n = 0;
    end else if (pix_ce) begin
      n = n + 1;
      #1;
      total++;
      if (panel.frame_start !== ((n - 1) % FRAME == 0)) begin
        bad++;
        $display("FAIL frame_start after pulse %0d: got %b want %b", n, panel.frame_start,
                 ((n - 1) % FRAME == 0));
      end
      if (n >= 2) check_out(n - 2);
    end
  end

  task automatic check_reset(input string name);
    total++;
    if ({panel.data_RED, panel.data_GREEN, panel.data_BLUE} !== 24'h0 || panel.DE !== 1'b0 ||
        panel.hsync_n !== 1'b1 || panel.vsync_n !== 1'b1 || panel.frame_start !== 1'b0) begin
      bad++;
      $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b fs=%b, want rgb=000000 de=0 hs=1 vs=1 fs=0",
               name, {panel.data_RED, panel.data_GREEN, panel.data_BLUE}, panel.DE,
               panel.hsync_n, panel.vsync_n, panel.frame_start);
    end
  endtask

  task automatic run_to(input int target);
    while (m < target) begin
      @(negedge Clk) pix_ce = 1'b1;
      m++;
      @(negedge Clk) pix_ce = 1'b0;
    end
  endtask

  initial begin
    repeat (5) @(negedge Clk);
    check_reset("reset_hold");

    // frame 0: no keys; a mid-frame key change must not show
    px(0, 5, 3, C_BG);
    px(0, 10, 15, C_BK);
    px(0, 11, 15, C_BK);
    px(0, 30, 15, C_WH);
    px(0, 34, 15, C_WH);
    px(0, 36, 15, C_WH);
    px(0, 5, 25, C_WH);
    px(0, 10, 25, C_WH);
    px(0, 11, 25, EDGE_UNPR);
    px(0, 90, 25, C_BG);
    push(0, 103, 25, C_BK, 1'b0, 1'b0, 1'b1);
    push(0, 5, 43, C_BK, 1'b0, 1'b1, 1'b0);
    m = 0;
    rst = 1'b1;
    run_to(20 * HT);
    key_down = 12'h003;
    run_to(FRAME);

    // frame 1: C and C# pressed
    px(1, 8, 15, C_HW);
    px(1, 10, 15, C_HB);
    px(1, 11, 15, C_HB);
    px(1, 12, 15, C_HB);
    px(1, 14, 15, C_HB);
    px(1, 15, 15, C_WH);
    px(1, 5, 25, C_HW);
    px(1, 11, 25, EDGE_PRESSED);
    px(1, 12, 25, C_WH);
    run_to(FRAME + 20 * HT);
    key_down = 12'h004;
    run_to(2 * FRAME);

    // frame 2: D pressed
    px(2, 10, 15, C_BK);
    px(2, 20, 15, C_HW);
    px(2, 21, 15, C_BK);
    px(2, 5, 25, C_WH);
    px(2, 12, 25, C_HW);
    run_to(3 * FRAME);

    // frame 3: B changes on the very latch cycle
    px(3, 74, 15, C_BK);
    px(3, 75, 15, C_HW);
    px(3, 80, 25, C_HW);
    px(3, 83, 25, EDGE_PRESSED);
    px(3, 84, 25, C_BG);
    @(negedge Clk);
    key_down = 12'h800;
    pix_ce = 1'b1;
    m++;
    @(negedge Clk) pix_ce = 1'b0;
    run_to(3 * FRAME + 30 * HT);

    // mid-frame reset, then a fresh frame with E pressed
    @(negedge Clk);
    rst = 1'b0;
    epoch = 1;
    #1 check_reset("reset_mid");
    key_down = 12'h010;
    repeat (5) @(negedge Clk);
    check_reset("reset_mid_hold");
    px(0, 26, 15, C_BK);
    px(0, 27, 15, C_HW);
    px(0, 5, 25, C_WH);
    px(0, 30, 25, C_HW);
    m = 0;
    rst = 1'b1;
    run_to(26 * HT + 10);
    repeat (4) @(negedge Clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending probes, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
